// File: rtl/stage_5_bitstream_packer_pkg.sv
// Shared definitions for stage 5 of the 4-bool entropy encoder:
// input geometry, flag width and the packer FSM encoding.
package stage_5_bitstream_packer_pkg;

    localparam int S5_MAX_IN_BYTES = 10;
    localparam int S5_GROUP_BYTES  = 5;
    localparam int S5_FLAG_WIDTH   = 3;
    localparam int S5_COUNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        S5_RUN   = 2'd0,
        S5_FLUSH = 2'd1,
        S5_DONE  = 2'd2
    } s5_state_e;

    // Stage 4 never legitimately sends more than five bytes per group.
    function automatic logic [S5_FLAG_WIDTH-1:0] s5_clamp_flag(input logic [S5_FLAG_WIDTH-1:0] f);
        return (f > 3'd5) ? 3'd5 : f;
    endfunction

endpackage

// File: rtl/stage_5_bitstream_packer_if.sv
// Stage 4 -> stage 5 byte groups and the packed word stream towards the consumer.
// master: the side driving bytes in and accepting beats; slave: the packer.
interface stage_5_bitstream_packer_if #(
    parameter int S5_BITSTREAM_WIDTH = 8,
    parameter int S5_OUT_BYTES       = 4
);
    logic [S5_BITSTREAM_WIDTH-1:0] in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5;
    logic [S5_BITSTREAM_WIDTH-1:0] in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5;
    logic [2:0]                    in_flag_1;
    logic [2:0]                    in_flag_2;
    logic                          in_flag_last;
    logic                          in_ready;

    logic [S5_BITSTREAM_WIDTH*S5_OUT_BYTES-1:0] out_data;
    logic [S5_OUT_BYTES-1:0]                    out_keep;
    logic                                       out_valid;
    logic                                       out_last;
    logic                                       out_ready;

    modport master (
        output in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5,
        output in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5,
        output in_flag_1, in_flag_2, in_flag_last, out_ready,
        input  in_ready, out_data, out_keep, out_valid, out_last
    );

    modport slave (
        input  in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5,
        input  in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5,
        input  in_flag_1, in_flag_2, in_flag_last, out_ready,
        output in_ready, out_data, out_keep, out_valid, out_last
    );

endinterface

// File: rtl/stage_5_bitstream_packer_byte_compactor.sv
// s5_byte_compactor: squeezes the two up-to-5-byte groups into one contiguous
// 10-byte vector (group 1 first) and reports the total byte count n.
// Purely combinational; out-of-range flags are clamped to 5.
module s5_byte_compactor
    import stage_5_bitstream_packer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [S5_GROUP_BYTES-1:0][W-1:0]  grp_1,
    input  logic [S5_GROUP_BYTES-1:0][W-1:0]  grp_2,
    input  logic [S5_FLAG_WIDTH-1:0]          flag_1,
    input  logic [S5_FLAG_WIDTH-1:0]          flag_2,
    output logic [S5_MAX_IN_BYTES-1:0][W-1:0] bytes,
    output logic [S5_COUNT_WIDTH-1:0]         n
);

    logic [S5_FLAG_WIDTH-1:0] f1, f2;

    // Place group-1 bytes at 0..f1-1 and group-2 bytes right after them.
    always_comb begin
        f1    = s5_clamp_flag(flag_1);
        f2    = s5_clamp_flag(flag_2);
        n     = {1'b0, f1} + {1'b0, f2};
        bytes = '0;
        for (int i = 0; i < S5_GROUP_BYTES; i++) begin
            if (i < int'(f1)) bytes[i] = grp_1[i];
        end
        for (int j = 0; j < S5_GROUP_BYTES; j++) begin
            if (j < int'(f2)) bytes[4'(f1) + 4'(j)] = grp_2[j];
        end
    end

endmodule

// File: rtl/stage_5_bitstream_packer.sv
// stage_5_bitstream_packer: buffers up to ten bitstream bytes per cycle in a
// circular byte FIFO and emits little-endian packed words. An accepted
// in_flag_last flushes the remainder as a final keep-masked beat with out_last.
// Optional feature macro: S5_OVERFLOW_CHECK_EN (sticky overflow_err, drops
// offending input). Without it overflow_err is tied low.
module stage_5_bitstream_packer
    import stage_5_bitstream_packer_pkg::*;
#(
    parameter int S5_BITSTREAM_WIDTH = 8,
    parameter int S5_OUT_BYTES       = 4,
    parameter int S5_FIFO_DEPTH      = 32,
    parameter int S5_PTR_WIDTH       = 5
) (
    input  logic                      s5_clk,
    input  logic                      s5_reset,
    stage_5_bitstream_packer_if.slave bus,
    output logic                      overflow_err
);

    localparam int                W          = S5_BITSTREAM_WIDTH;
    localparam int                PW         = S5_PTR_WIDTH;
    localparam logic [PW:0]       OUT_BYTES_C = (PW+1)'(S5_OUT_BYTES);
    localparam logic [PW+1:0]     DEPTH_C     = (PW+2)'(S5_FIFO_DEPTH);
    localparam logic [PW+1:0]     MAX_IN_C    = (PW+2)'(S5_MAX_IN_BYTES);

    // Storage carries no reset: only the pointers define what is live.
    logic [W-1:0] mem [S5_FIFO_DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PW:0]   wr_ptr, rd_ptr, count, pop_n;
    logic [PW+1:0] free;

    s5_state_e state_q, state_d;

    logic [S5_GROUP_BYTES-1:0][W-1:0]  grp_1, grp_2;
    logic [S5_MAX_IN_BYTES-1:0][W-1:0] bytes;
    logic [S5_COUNT_WIDTH-1:0]         n;

    logic                          in_ready;
    logic                          accept;
    logic                          bad_in;
    logic                          out_valid, out_last;
    logic [S5_OUT_BYTES-1:0]       out_keep;
    logic [W*S5_OUT_BYTES-1:0]     out_data;

    assign grp_1 = {bus.in_bit_1_5, bus.in_bit_1_4, bus.in_bit_1_3, bus.in_bit_1_2, bus.in_bit_1_1};
    assign grp_2 = {bus.in_bit_2_5, bus.in_bit_2_4, bus.in_bit_2_3, bus.in_bit_2_2, bus.in_bit_2_1};

    s5_byte_compactor #(.W(W)) u_compactor (
        .grp_1  (grp_1),
        .grp_2  (grp_2),
        .flag_1 (bus.in_flag_1),
        .flag_2 (bus.in_flag_2),
        .bytes  (bytes),
        .n      (n)
    );

    assign count = wr_ptr - rd_ptr;
    assign free  = DEPTH_C - {1'b0, count};

    // Registered state only: room for a worst-case input and frame not finished.
    assign in_ready = (free >= MAX_IN_C) && (state_q != S5_DONE);
    assign accept   = in_ready && !bad_in;

`ifdef S5_OVERFLOW_CHECK_EN
    logic flag_bad;
    assign flag_bad = (bus.in_flag_1 > 3'd5) || (bus.in_flag_2 > 3'd5);
    // Malformed flags mean the group boundaries cannot be trusted; drop the input.
    assign bad_in   = flag_bad;

    // Sticky error: data or end-of-frame offered with no room, or malformed flags.
    always_ff @(posedge s5_clk) begin
        if (s5_reset)
            overflow_err <= 1'b0;
        else if (flag_bad || (!in_ready && ((n != '0) || bus.in_flag_last)))
            overflow_err <= 1'b1;
    end
`else
    assign bad_in       = 1'b0;
    assign overflow_err = 1'b0;
`endif

    // Write the compacted bytes in stream order at wr_ptr, wr_ptr+1, ...
    always_ff @(posedge s5_clk) begin
        if (accept) begin
            for (int i = 0; i < S5_MAX_IN_BYTES; i++) begin
                if (4'(i) < n) mem[wr_ptr[PW-1:0] + PW'(i)] <= bytes[i];
            end
        end
    end

    // Pointer update: push and pop in the same cycle are both applied.
    always_ff @(posedge s5_clk) begin
        if (s5_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (PW+1)'(n);
            rd_ptr <= rd_ptr + pop_n;
        end
    end

    // FSM state register.
    always_ff @(posedge s5_clk) begin
        if (s5_reset) state_q <= S5_RUN;
        else          state_q <= state_d;
    end

    // Next state, beat qualifiers and the number of bytes popped this cycle.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_keep  = '0;
        pop_n     = '0;
        case (state_q)
            S5_RUN: begin
                out_valid = (count >= OUT_BYTES_C);
                out_keep  = out_valid ? '1 : '0;
                if (accept && bus.in_flag_last) state_d = S5_FLUSH;
            end
            S5_FLUSH: begin
                out_valid = 1'b1;
                out_last  = (count <= OUT_BYTES_C);
                for (int j = 0; j < S5_OUT_BYTES; j++) out_keep[j] = (count > (PW+1)'(j));
                if (bus.out_ready && out_last) state_d = S5_DONE;
            end
            S5_DONE: begin
                state_d = S5_DONE;
            end
            default: state_d = S5_RUN;
        endcase
        if (out_valid && bus.out_ready) begin
            for (int j = 0; j < S5_OUT_BYTES; j++) pop_n = pop_n + (PW+1)'(out_keep[j]);
        end
    end

    // Oldest byte in the LSB lane; unkept lanes read as zero.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < S5_OUT_BYTES; j++) begin
            if (out_keep[j]) out_data[j*W +: W] = mem[rd_ptr[PW-1:0] + PW'(j)];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_keep  = out_keep;
    assign bus.out_data  = out_data;

endmodule
